down_counter_reload: RTL and testbench
======================================

Name: down_counter_reload

Overview:
Loadable down counter with terminal-count signalling. It is the counting-down companion to the team's free-running up counter. Software or an upstream FSM loads a start value and starts the count. The block decrements on enabled cycles and flags terminal count. It runs either once (one-shot) or periodically with automatic reload (auto-reload). Intended uses are timeouts, programmable tick generators and transfer-length countdown.

Parameters:
WIDTH, 4, bit width of the counter, the reload register and load_val (WIDTH >= 2)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  capture load_val into count and reload register
load_val  input  WIDTH  value captured on load
start  input  1  begin counting from the current count, or restart from DONE
stop  input  1  pause; RUN -> IDLE, count held
en  input  1  count enable; decrement only on cycles with en=1 while in RUN
mode  input  1  0 = one-shot, 1 = auto-reload; sampled live every cycle
count  output  WIDTH  current counter value
tc  output  1  terminal-count pulse, registered, one cycle wide
busy  output  1  high while state = RUN
done  output  1  high while state = DONE (one-shot completed)

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: count=0, reload register=0, state=IDLE, tc=0, busy=0, done=0.
- Priority, evaluated each rising edge: rst > load > stop > start > en.
- Internal state: reload register (WIDTH bits), count (WIDTH bits), FSM {IDLE, RUN, DONE}.
- load (any state): count<=load_val, reload<=load_val, state<=IDLE, tc<=0.
- IDLE:
  - count is held; en is ignored.
  - start with count!=0 -> RUN.
  - start with count==0 is ignored and the state stays IDLE.
- RUN:
  - stop -> IDLE, count held, no tc.
  - en=0 -> count held.
  - en=1 and count>1 -> count<=count-1.
  - en=1 and count==1 and mode=0 -> count<=0, tc<=1, state<=DONE.
  - en=1 and count==1 and mode=1 -> count<=reload, tc<=1, state stays RUN. A reload of 1 gives tc on every enabled cycle.
  - The count==0 case in RUN is unreachable by construction. If it occurs, go to IDLE.
- DONE:
  - count is held at 0; en is ignored.
  - start with reload!=0 -> count<=reload, RUN.
  - start with reload==0 is ignored.
  - load -> IDLE as above.
- tc:
  - High for exactly the one cycle following the enabled edge at which count left the value 1. Low at all other times.
  - In one-shot mode, tc is coincident with count==0 and done rising.
  - In auto-reload mode, tc is coincident with count showing the reload value.
- Period: in auto-reload mode with en held at 1, tc repeats every N cycles, where N = reload value.
- Width rules:
  - Plain unsigned arithmetic.
  - The counter never wraps below 0. No underflow to all-ones in any mode.
  - Maximum load value is 2^WIDTH-1.
- Mode change mid-run takes effect at the next count==1 event.
- Reset mid-RUN or mid-DONE: all state returns to reset values on that edge. The reload register is cleared too.

Test Plan:
1. Reset mid-run: load 4'd9, start, en=1 for 3 cycles, rst=1 for 1 cycle -> next edge count=0, busy=0, done=0, tc=0. start afterwards is ignored (count 0).
2. One-shot: load 4'd3, mode=0, start, en=1 -> count 3,2,1,0. tc=1 for one cycle with count=0. done=1, busy=0. Further en leaves count at 0 and tc at 0.
3. Auto-reload: load 4'd2, mode=1, start, en=1 -> count 2,1,2,1,... and tc=1 each time count returns to 2 (period 2). Repeat with load 4'd1 -> tc high every cycle, count stays 1.
4. Enable gaps: load 4'd4, mode=0, start, en pattern 1,0,0,1,1,0,1 -> count changes only on en=1 cycles (4,3,3,3,2,1,1,0). tc only after the final enabled edge.
5. Max value, no wrap: load 4'hF, mode=0, start, en=1 -> exactly 15 enabled cycles to reach 0, then tc. Count never shows 4'hF again. start from DONE reloads to 4'hF and enters RUN.
6. Priority: load+start in the same cycle -> IDLE, count=load_val, busy=0. stop+en in RUN -> count held, busy=0. start+stop in RUN -> IDLE.

Source files
------------

// File: rtl/down_counter_reload.sv
// Loadable down counter with terminal-count pulse, one-shot or auto-reload operation.
// Every output comes straight from a flop; busy/done are registered copies of the next state.
module down_counter_reload #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!stop && start && (count_q != '0)) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StIdle;
                    end else if (count_q == '0) begin
                        // Unreachable in normal operation; recover to a safe idle state.
                        state_d = StIdle;
                    end else if (en) begin
                        if (count_q != WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (mode) begin
                            count_d = reload_q;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = '0;
                            tc_d    = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (!stop && start && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Scoreboard bench for down_counter_reload: each step pushes its expected outputs, drives one
// cycle of stimulus, then pops and compares against what the counter shows after the edge.
module tb_down_counter_reload;

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [3:0] lv;
        logic       start;
        logic       stop;
        logic       en;
        logic       mode;
    } stim_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    obs_t sb[$];

    down_counter_reload #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic stim_t sv(input logic r, input logic l, input logic [3:0] v,
                                 input logic go, input logic sp, input logic e, input logic m);
        sv = '{rst: r, load: l, lv: v, start: go, stop: sp, en: e, mode: m};
    endfunction

    function automatic obs_t ov(input logic [3:0] c, input logic t, input logic b,
                                input logic d);
        ov = '{cnt: c, tc: t, busy: b, done: d};
    endfunction

    // Drive one cycle of inputs, let the edge happen, settle 1 time unit past it.
    task automatic tick(input stim_t s);
        rst      = s.rst;
        load     = s.load;
        load_val = s.lv;
        start    = s.start;
        stop     = s.stop;
        en       = s.en;
        mode     = s.mode;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, e;
        st.push_back(sv(1, 0, 4'd0, 0, 0, 0, 0)); ex.push_back(ov(4'd0, 0, 0, 0));
        st.push_back(sv(1, 1, 4'd7, 1, 0, 1, 1)); ex.push_back(ov(4'd0, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 0, 0)); ex.push_back(ov(4'd0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            got = '{cnt: count, tc: tc, busy: busy, done: done};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset step %0d: got cnt=%0d tc=%0b busy=%0b done=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b",
                         i, got.cnt, got.tc, got.busy, got.done, e.cnt, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, e;
        st.push_back(sv(0, 1, 4'd9, 0, 0, 0, 0)); ex.push_back(ov(4'd9, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'd9, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd8, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd7, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd6, 0, 1, 0));
        st.push_back(sv(1, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd0, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'd0, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 1, 0)); ex.push_back(ov(4'd0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            got = '{cnt: count, tc: tc, busy: busy, done: done};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_run step %0d: got cnt=%0d tc=%0b busy=%0b done=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b",
                         i, got.cnt, got.tc, got.busy, got.done, e.cnt, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_one_shot();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, e;
        st.push_back(sv(0, 1, 4'd3, 0, 0, 0, 0)); ex.push_back(ov(4'd3, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'd3, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd2, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd1, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd0, 1, 0, 1));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd0, 0, 0, 1));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd0, 0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            got = '{cnt: count, tc: tc, busy: busy, done: done};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL one_shot step %0d: got cnt=%0d tc=%0b busy=%0b done=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b",
                         i, got.cnt, got.tc, got.busy, got.done, e.cnt, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_auto_reload();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, e;
        st.push_back(sv(0, 1, 4'd2, 0, 0, 0, 1)); ex.push_back(ov(4'd2, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 1)); ex.push_back(ov(4'd2, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 1)); ex.push_back(ov(4'd1, 0, 1, 0));
            st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 1)); ex.push_back(ov(4'd2, 1, 1, 0));
        end
        // Switching to one-shot mid-run applies at the next count==1 event.
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd1, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd0, 1, 0, 1));
        st.push_back(sv(0, 1, 4'd1, 0, 0, 0, 1)); ex.push_back(ov(4'd1, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 1)); ex.push_back(ov(4'd1, 0, 1, 0));
        for (int k = 0; k < 4; k++) begin
            st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 1)); ex.push_back(ov(4'd1, 1, 1, 0));
        end
        st.push_back(sv(0, 0, 4'd0, 0, 0, 0, 1)); ex.push_back(ov(4'd1, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 1, 0, 1)); ex.push_back(ov(4'd1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            got = '{cnt: count, tc: tc, busy: busy, done: done};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL auto_reload step %0d: got cnt=%0d tc=%0b busy=%0b done=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b",
                         i, got.cnt, got.tc, got.busy, got.done, e.cnt, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_enable_gaps();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, e;
        logic [6:0] pat;
        logic [3:0] c;
        pat = 7'b1001101;  // applied MSB first: 1,0,0,1,1,0,1
        c = 4'd4;
        st.push_back(sv(0, 1, 4'd4, 0, 0, 0, 0)); ex.push_back(ov(4'd4, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'd4, 0, 1, 0));
        for (int k = 6; k >= 0; k--) begin
            if (pat[k]) c = c - 4'd1;
            st.push_back(sv(0, 0, 4'd0, 0, 0, pat[k], 0));
            ex.push_back(ov(c, (k == 0), (k != 0), (k == 0)));
        end
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            got = '{cnt: count, tc: tc, busy: busy, done: done};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL enable_gaps step %0d: got cnt=%0d tc=%0b busy=%0b done=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b",
                         i, got.cnt, got.tc, got.busy, got.done, e.cnt, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_max_value();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, e;
        st.push_back(sv(0, 1, 4'hF, 0, 0, 0, 0)); ex.push_back(ov(4'hF, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'hF, 0, 1, 0));
        for (int k = 14; k >= 1; k--) begin
            st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'(k), 0, 1, 0));
        end
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd0, 1, 0, 1));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'd0, 0, 0, 1));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'hF, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 0, 1, 0)); ex.push_back(ov(4'hE, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 1, 0, 0)); ex.push_back(ov(4'hE, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            got = '{cnt: count, tc: tc, busy: busy, done: done};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL max_value step %0d: got cnt=%0d tc=%0b busy=%0b done=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b",
                         i, got.cnt, got.tc, got.busy, got.done, e.cnt, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, e;
        st.push_back(sv(0, 1, 4'd5, 1, 0, 0, 0)); ex.push_back(ov(4'd5, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'd5, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 0, 1, 1, 0)); ex.push_back(ov(4'd5, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'd5, 0, 1, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 1, 0, 0)); ex.push_back(ov(4'd5, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 0, 0)); ex.push_back(ov(4'd5, 0, 1, 0));
        st.push_back(sv(0, 1, 4'd1, 0, 1, 1, 0)); ex.push_back(ov(4'd1, 0, 0, 0));
        st.push_back(sv(0, 1, 4'd0, 0, 0, 0, 0)); ex.push_back(ov(4'd0, 0, 0, 0));
        st.push_back(sv(0, 0, 4'd0, 1, 0, 1, 0)); ex.push_back(ov(4'd0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            got = '{cnt: count, tc: tc, busy: busy, done: done};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL priority step %0d: got cnt=%0d tc=%0b busy=%0b done=%0b, expected cnt=%0d tc=%0b busy=%0b done=%0b",
                         i, got.cnt, got.tc, got.busy, got.done, e.cnt, e.tc, e.busy, e.done);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_mid_run();
        test_one_shot();
        test_auto_reload();
        test_enable_gaps();
        test_max_value();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
